// File: rtl/mdarray_pkg.sv
// Shared types and constants for the 3-D byte array sequencer and its array.
package mdarray_pkg;

  localparam int unsigned W      = 2;
  localparam int unsigned RD_LAT = 2;

  typedef enum logic [1:0] {IDLE, LOAD, READ, FLUSH} state_e;

  typedef logic [W:0] idx_t;
  typedef logic [7:0] byte_t;

endpackage

// File: rtl/mdarray_sequencer_if.sv
// Bundles the load stream, array port and readback stream of the sequencer.
interface mdarray_sequencer_if
  import mdarray_pkg::*;
#(
  parameter int unsigned w = W
);

  logic       start;
  logic       load_en;
  logic       in_valid;
  byte_t      in_data;
  logic       in_ready;
  logic [w:0] col;
  logic [w:0] row;
  logic [w:0] slc;
  byte_t      data_i;
  logic       wr;
  byte_t      data_o;
  logic       out_valid;
  byte_t      out_data;
  logic [w:0] out_col;
  logic [w:0] out_row;
  logic [w:0] out_slc;
  logic       busy;
  logic       done;

  modport master (
    input  start, load_en, in_valid, in_data, data_o,
    output in_ready, col, row, slc, data_i, wr,
           out_valid, out_data, out_col, out_row, out_slc, busy, done
  );

  modport slave (
    output start, load_en, in_valid, in_data, data_o,
    input  in_ready, col, row, slc, data_i, wr,
           out_valid, out_data, out_col, out_row, out_slc, busy, done
  );

endinterface

// File: rtl/mdarray_index_counter.sv
// Raster-order slc/row/col counter: col fastest, then row, then slc.
module mdarray_index_counter #(
  parameter int unsigned w = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [w:0] c,
  output logic [w:0] r,
  output logic [w:0] s,
  output logic       last_c
);

  localparam int unsigned IW  = w + 1;
  localparam logic [w:0]  MAX = IW'(w);

  assign last_c = (s == MAX) && (r == MAX) && (c == MAX);

  // clear wins over enable so the final advance lands back on (0,0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= '0;
      r <= '0;
      s <= '0;
    end else if (clr) begin
      c <= '0;
      r <= '0;
      s <= '0;
    end else if (en) begin
      if (c == MAX) begin
        c <= '0;
        if (r == MAX) begin
          r <= '0;
          s <= (s == MAX) ? '0 : s + IW'(1);
        end else begin
          r <= r + IW'(1);
        end
      end else begin
        c <= c + IW'(1);
      end
    end
  end

endmodule

// File: rtl/mdarray_sequencer.sv
// Loads the 3-D array from a byte stream, then reads it back in raster order
// with index tags aligned to the array's read latency.
module mdarray_sequencer
  import mdarray_pkg::*;
#(
  parameter int unsigned w = W
) (
  input  logic                clock,
  input  logic                reset_n,
  mdarray_sequencer_if.master bus
);

  localparam int unsigned FW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef struct packed {
    logic [w:0] s;
    logic [w:0] r;
    logic [w:0] c;
  } tag_t;

  state_e        state;
  logic [FW-1:0] flush_cnt;
  logic          busy_q;
  logic          in_ready_q;
  logic          done_q;
  logic          v1;
  logic          v2;
  tag_t          tag1;
  tag_t          tag2;

  logic [w:0]    c;
  logic [w:0]    r;
  logic [w:0]    s;
  logic          last_c;
  logic          adv_c;
  logic          clr_c;

  assign adv_c = ((state == LOAD) && bus.in_valid) || (state == READ);
  assign clr_c = ((state == IDLE) && bus.start) || (adv_c && last_c);

  mdarray_index_counter #(.w(w)) u_cnt (
    .clk    (clock),
    .rst_n  (reset_n),
    .clr    (clr_c),
    .en     (adv_c),
    .c      (c),
    .r      (r),
    .s      (s),
    .last_c (last_c)
  );

  // Array port: writes pass straight through while loading
  assign bus.col    = c;
  assign bus.row    = r;
  assign bus.slc    = s;
  assign bus.wr     = (state == LOAD) && bus.in_valid;
  assign bus.data_i = (state == LOAD) ? bus.in_data : '0;

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = v2;
  assign bus.out_data  = bus.data_o;
  assign bus.out_col   = tag2.c;
  assign bus.out_row   = tag2.r;
  assign bus.out_slc   = tag2.s;

  // FSM with registered status outputs and the 2-deep read tag pipe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      flush_cnt  <= '0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      tag1       <= '0;
      tag2       <= '0;
    end else begin
      done_q <= 1'b0;
      v1     <= (state == READ);
      tag1   <= '{s: s, r: r, c: c};
      v2     <= v1;
      tag2   <= tag1;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= bus.load_en ? LOAD : READ;
            busy_q     <= 1'b1;
            in_ready_q <= bus.load_en;
          end
        end
        LOAD: begin
          if (bus.in_valid && last_c) begin
            state      <= READ;
            in_ready_q <= 1'b0;
          end
        end
        READ: begin
          if (last_c) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          if (flush_cnt == FW'(RD_LAT - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdarray_sequencer.sv
// Randomized bench: drives load/read sequences against a behavioural array and
// checks writes and tagged readback against a raster-order reference.
module tb_mdarray_sequencer;
  import mdarray_pkg::*;

  localparam int unsigned D  = W + 1;
  localparam int unsigned NE = D * D * D;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mdarray_sequencer_if #(.w(W)) bus ();

  mdarray_sequencer #(.w(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural array: write on clock, read data two cycles after address
  byte_t mem [NE];
  byte_t rd1;

  function automatic int unsigned flat(input int unsigned sv, input int unsigned rv,
                                       input int unsigned cv);
    return (sv * D + rv) * D + cv;
  endfunction

  always @(posedge clock) begin
    if (bus.wr) mem[flat(32'(bus.slc), 32'(bus.row), 32'(bus.col))] <= bus.data_i;
    rd1         <= mem[flat(32'(bus.slc), 32'(bus.row), 32'(bus.col))];
    bus.data_o  <= rd1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  // Reference: k-th element in raster order, stimulus bytes and expected contents
  byte_t exp_bytes [NE];
  byte_t model_mem [NE];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int wr_cnt, rd_cnt, first_wr, last_wr, first_ov, last_ov, done_cyc;

  task automatic clr_stats();
    wr_cnt = 0; rd_cnt = 0;
    first_wr = -1; last_wr = -1; first_ov = -1; last_ov = -1; done_cyc = -1;
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.wr) begin
        if (wr_cnt == 0) first_wr = cyc;
        last_wr = cyc;
        if (wr_cnt < int'(NE)) begin
          check("wr_col",  32'(bus.col),    32'(wr_cnt) % D);
          check("wr_row",  32'(bus.row),    (32'(wr_cnt) / D) % D);
          check("wr_slc",  32'(bus.slc),    32'(wr_cnt) / (D * D));
          check("wr_data", 32'(bus.data_i), 32'(exp_bytes[wr_cnt]));
        end else begin
          check("wr_extra", 32'(wr_cnt), NE - 1);
        end
        wr_cnt++;
      end
      if (bus.out_valid) begin
        if (rd_cnt == 0) first_ov = cyc;
        last_ov = cyc;
        if (rd_cnt < int'(NE)) begin
          check("rd_col",  32'(bus.out_col),  32'(rd_cnt) % D);
          check("rd_row",  32'(bus.out_row),  (32'(rd_cnt) / D) % D);
          check("rd_slc",  32'(bus.out_slc),  32'(rd_cnt) / (D * D));
          check("rd_data", 32'(bus.out_data), 32'(model_mem[rd_cnt]));
        end else begin
          check("rd_extra", 32'(rd_cnt), NE - 1);
        end
        rd_cnt++;
      end
      if (bus.done) begin
        done_cyc = cyc;
        check("done_busy", 32'(bus.busy), 0);
        check("done_ov",   32'(bus.out_valid), 0);
      end
    end
  end

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_busy"},     32'(bus.busy),      0);
    check({pfx, "_in_ready"}, 32'(bus.in_ready),  0);
    check({pfx, "_wr"},       32'(bus.wr),        0);
    check({pfx, "_out_valid"},32'(bus.out_valid), 0);
    check({pfx, "_done"},     32'(bus.done),      0);
    check({pfx, "_addr"},     32'({bus.slc, bus.row, bus.col}), 0);
    check({pfx, "_data_i"},   32'(bus.data_i),    0);
    check({pfx, "_tags"},     32'({bus.out_slc, bus.out_row, bus.out_col}), 0);
  endtask

  task automatic start_seq(input bit ld, output int s_cyc);
    @(posedge clock); #1;
    bus.start   = 1'b1;
    bus.load_en = ld;
    @(negedge clock);
    s_cyc = cyc;
    @(posedge clock); #1;
    bus.start   = 1'b0;
    bus.load_en = 1'($urandom_range(0, 1));
  endtask

  // Called at the start of the first LOAD cycle; each beat checks wr against in_valid
  task automatic load_bytes(input int gap_max, input int n, input bit poke_start);
    for (int k = 0; k < n; k++) begin
      int gaps = $urandom_range(0, gap_max);
      for (int g = 0; g < gaps; g++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.start    = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clock);
        check("gap_wr",       32'(bus.wr),       0);
        check("gap_in_ready", 32'(bus.in_ready), 1);
        @(posedge clock); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = exp_bytes[k];
      bus.start    = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clock);
      check("ld_in_ready", 32'(bus.in_ready), 1);
      check("ld_wr",       32'(bus.wr),       1);
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (bus.done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 1);
    @(negedge clock);
    check("done_pulse", 32'(bus.done), 0);
    check("idle_busy",  32'(bus.busy), 0);
    @(posedge clock); #1;
  endtask

  task automatic check_readback();
    check("rd_count",  32'(rd_cnt), NE);
    check("ov_span",   32'(last_ov - first_ov), NE - 1);
    check("done_lat",  32'(done_cyc), 32'(last_ov + 1));
  endtask

  task automatic full_load(input int gap_max, input bit poke_start, input bit inc);
    int s_cyc;
    for (int k = 0; k < int'(NE); k++)
      exp_bytes[k] = inc ? 8'(8'h10 + k) : 8'($urandom);
    clr_stats();
    start_seq(1'b1, s_cyc);
    load_bytes(gap_max, int'(NE), poke_start);
    model_mem = exp_bytes;
    wait_done();
    check("wr_count", 32'(wr_cnt), NE);
    check("wr_first", 32'(first_wr), 32'(s_cyc + 1));
    if (gap_max == 0) check("wr_span", 32'(last_wr - first_wr), NE - 1);
    check("rd_first", 32'(first_ov), 32'(last_wr + 3));
    check_readback();
  endtask

  initial begin
    int s_cyc;
    bus.start    = 1'b0;
    bus.load_en  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    clr_stats();
    #1;
    check_idle_outputs("rst");
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Back-to-back load of 0x10.. followed by automatic readback
    full_load(0, 1'b0, 1'b1);

    // Stalled load with start pokes that must be ignored
    full_load(3, 1'b1, 1'b0);

    // Read-only pass over the current contents
    clr_stats();
    start_seq(1'b0, s_cyc);
    @(negedge clock);
    check("ro_busy",     32'(bus.busy),     1);
    check("ro_in_ready", 32'(bus.in_ready), 0);
    check("ro_addr0",    32'({bus.slc, bus.row, bus.col}), 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);
    wait_done();
    bus.in_valid = 1'b0;
    check("ro_wr_count", 32'(wr_cnt), 0);
    check("ro_rd_first", 32'(first_ov), 32'(s_cyc + 3));
    check_readback();

    // Asynchronous reset after five writes, then a fresh load from (0,0,0)
    for (int k = 0; k < int'(NE); k++) exp_bytes[k] = 8'($urandom);
    clr_stats();
    start_seq(1'b1, s_cyc);
    load_bytes(1, 5, 1'b0);
    check("pre_rst_wr_count", 32'(wr_cnt), 5);
    bus.in_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    bus.in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    full_load(1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
